// File: rtl/prom_fetch_sequencer.sv
// Instruction-fetch sequencer for the TRSQ8 program ROM.
// Owns the fetch address (FA) and presents one instruction per cycle to the decoder.
// Jump/call/return redirects and a single vectored interrupt are handled here,
// backed by a small hardware return stack.
// Handshake: there is no backpressure toward the ROM. INSTR_op/PC_op are meaningful
// only while INSTR_VALID_op=1. The decoder's redirect inputs are taken only in a
// cycle where INSTR_VALID_op=1 and STALL_ip=0; otherwise they are dropped, not queued.
module prom_fetch_sequencer #(
    parameter int                ADDR_W      = 13,
    parameter int                DATA_W      = 15,
    parameter int                STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC   = 13'd0,
    parameter logic [ADDR_W-1:0] IRQ_VEC     = 13'd4
) (
    input  logic              CLK_ip,
    input  logic              RST_ip,
    output logic [ADDR_W-1:0] PROM_ADDR_op,
    input  logic [DATA_W-1:0] PROM_DATA_ip,
    input  logic              STALL_ip,
    input  logic              JUMP_ip,
    input  logic              CALL_ip,
    input  logic              RET_ip,
    input  logic              RETI_ip,
    input  logic [ADDR_W-1:0] TARGET_ip,
    input  logic              IRQ_ip,
    input  logic              INT_EN_ip,
    output logic [DATA_W-1:0] INSTR_op,
    output logic              INSTR_VALID_op,
    output logic [ADDR_W-1:0] PC_op,
    output logic              IRQ_ACK_op,
    output logic              STACK_ERR_op
);

    // SP counts 0..STACK_DEPTH, so it needs one more code than the entry index.
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] fa_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] instr_q;
    logic              valid_q;
    logic              in_isr_q;
    logic              ack_q;
    logic              err_q;
    logic [SP_W-1:0]   sp_q;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic              do_ret;
    logic              do_call;
    logic              do_jump;
    logic              do_irq;
    logic              stack_full;
    logic              stack_empty;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;

    // Redirect priority decode (RETI/RET > CALL > JUMP) and interrupt qualification.
    always_comb begin
        do_ret      = valid_q & (RETI_ip | RET_ip);
        do_call     = valid_q & CALL_ip & ~(RETI_ip | RET_ip);
        do_jump     = valid_q & JUMP_ip & ~(RETI_ip | RET_ip | CALL_ip);
        // A taken redirect wins over the interrupt; the IRQ is simply looked at again next cycle.
        do_irq      = IRQ_ip & INT_EN_ip & ~in_isr_q & ~(do_ret | do_call | do_jump);
        stack_full  = (sp_q == SP_W'(STACK_DEPTH));
        stack_empty = (sp_q == '0);
        push_idx    = IDX_W'(sp_q);
        pop_idx     = IDX_W'(sp_q - SP_W'(1));
    end

    // Sequencer state: fetch address, decode-stage registers, return stack and flags.
    always_ff @(posedge CLK_ip) begin
        if (RST_ip) begin
            fa_q     <= RESET_VEC;
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            in_isr_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            sp_q     <= '0;
        end else if (STALL_ip) begin
            ack_q <= 1'b0;
        end else begin
            // The word at FA always moves to the decoder; redirects only squash its valid bit.
            instr_q <= PROM_DATA_ip;
            pc_q    <= fa_q;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            if (do_ret) begin
                if (stack_empty) begin
                    fa_q  <= RESET_VEC;
                    err_q <= 1'b1;
                end else begin
                    fa_q <= stack_q[pop_idx];
                    sp_q <= sp_q - SP_W'(1);
                end
                if (RETI_ip) begin
                    in_isr_q <= 1'b0;
                end
            end else if (do_call) begin
                if (stack_full) begin
                    err_q <= 1'b1;
                end else begin
                    stack_q[push_idx] <= pc_q + ADDR_W'(1);
                    sp_q              <= sp_q + SP_W'(1);
                end
                fa_q <= TARGET_ip;
            end else if (do_jump) begin
                fa_q <= TARGET_ip;
            end else if (do_irq) begin
                // The word being fetched is squashed, so its address is the return point.
                if (stack_full) begin
                    err_q <= 1'b1;
                end else begin
                    stack_q[push_idx] <= fa_q;
                    sp_q              <= sp_q + SP_W'(1);
                end
                fa_q     <= IRQ_VEC;
                in_isr_q <= 1'b1;
                ack_q    <= 1'b1;
            end else begin
                fa_q    <= fa_q + ADDR_W'(1);
                valid_q <= 1'b1;
            end
        end
    end

    assign PROM_ADDR_op   = fa_q;
    assign INSTR_op       = instr_q;
    assign INSTR_VALID_op = valid_q;
    assign PC_op          = pc_q;
    assign IRQ_ACK_op     = ack_q;
    assign STACK_ERR_op   = err_q;

endmodule

// File: tb/tb_prom_fetch_sequencer.sv
// Bench for prom_fetch_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a queue-based model.
module tb_prom_fetch_sequencer;

  localparam int AW = 13;
  localparam int DW = 15;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, stall, jump, call, ret, reti, irq, en;
  logic [AW-1:0] target;
  logic [AW-1:0] prom_addr;
  logic [DW-1:0] prom_data;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          irq_ack;
  logic          stack_err;

  // ROM contents: word[n] = n
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {2'b00, a};
  endfunction

  assign prom_data = rom_word(prom_addr);

  prom_fetch_sequencer dut (
    .CLK_ip        (clk),
    .RST_ip        (rst),
    .PROM_ADDR_op  (prom_addr),
    .PROM_DATA_ip  (prom_data),
    .STALL_ip      (stall),
    .JUMP_ip       (jump),
    .CALL_ip       (call),
    .RET_ip        (ret),
    .RETI_ip       (reti),
    .TARGET_ip     (target),
    .IRQ_ip        (irq),
    .INT_EN_ip     (en),
    .INSTR_op      (instr),
    .INSTR_VALID_op(instr_valid),
    .PC_op         (pc),
    .IRQ_ACK_op    (irq_ack),
    .STACK_ERR_op  (stack_err)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  logic [AW-1:0] m_fa, m_pc;
  logic [DW-1:0] m_instr;
  logic          m_valid, m_isr, m_ack, m_err;
  logic [AW-1:0] exp_q[$];   // return stack, top at the back

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Apply one clock edge's worth of architectural rules to the model.
  task automatic model_step();
    logic [AW-1:0] old_fa;
    logic          nv;
    old_fa = m_fa;
    if (rst) begin
      m_fa = 13'd0; m_pc = 13'd0; m_instr = '0; m_valid = 1'b0;
      m_isr = 1'b0; m_ack = 1'b0; m_err = 1'b0;
      exp_q.delete();
    end else if (stall) begin
      m_ack = 1'b0;
    end else begin
      m_ack = 1'b0;
      nv = 1'b0;
      if (m_valid && (reti || ret)) begin
        if (exp_q.size() == 0) begin
          m_fa = 13'd0;
          m_err = 1'b1;
        end else begin
          m_fa = exp_q.pop_back();
        end
        if (reti) m_isr = 1'b0;
      end else if (m_valid && call) begin
        if (exp_q.size() >= DEPTH) m_err = 1'b1;
        else exp_q.push_back(m_pc + 13'd1);
        m_fa = target;
      end else if (m_valid && jump) begin
        m_fa = target;
      end else if (irq && en && !m_isr) begin
        if (exp_q.size() >= DEPTH) m_err = 1'b1;
        else exp_q.push_back(old_fa);
        m_fa = 13'd4;
        m_isr = 1'b1;
        m_ack = 1'b1;
      end else begin
        m_fa = old_fa + 13'd1;
        nv = 1'b1;
      end
      m_instr = rom_word(old_fa);
      m_pc = old_fa;
      m_valid = nv;
    end
  endtask

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("prom_addr", 32'(prom_addr), 32'(m_fa));
      check("valid", 32'(instr_valid), 32'(m_valid));
      check("pc", 32'(pc), 32'(m_pc));
      check("instr", 32'(instr), 32'(m_instr));
      check("irq_ack", 32'(irq_ack), 32'(m_ack));
      check("stack_err", 32'(stack_err), 32'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Pin both the DUT and the model to a hand-computed PC.
  task automatic lit_pc(input string name, input logic [AW-1:0] exp);
    check({name, "_dut"}, 32'(pc), 32'(exp));
    check({name, "_model"}, 32'(m_pc), 32'(exp));
  endtask

  task automatic clear_inputs();
    stall = 0; jump = 0; call = 0; ret = 0; reti = 0; irq = 0; en = 0; target = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    rst = 1;
    m_fa = '0; m_pc = '0; m_instr = '0; m_valid = 0; m_isr = 0; m_ack = 0; m_err = 0;
    cycle();
    chk_en = 1'b1;
    cycle();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_addr", 32'(prom_addr), 32'd0);
    check("rst_err", 32'(stack_err), 32'd0);
    check("rst_ack", 32'(irq_ack), 32'd0);
    lit_pc("rst_pc", 13'd0);

    // sequential fetch from reset
    rst = 0;
    cycle();
    lit_pc("seq0", 13'd0);
    check("seq0_valid", 32'(instr_valid), 32'd1);
    check("seq0_addr", 32'(prom_addr), 32'd1);
    cycle();
    check("seq1_instr", 32'(instr), 32'd1);
    run(4);
    lit_pc("seq5", 13'd5);

    // jump 5 -> 20
    jump = 1; target = 13'd20;
    cycle();
    jump = 0;
    check("jmp_bubble", 32'(instr_valid), 32'd0);
    check("jmp_addr", 32'(prom_addr), 32'd20);
    cycle();
    lit_pc("jmp_pc", 13'd20);
    check("jmp_valid", 32'(instr_valid), 32'd1);

    // call from 15 to 32, return at 37
    jump = 1; target = 13'd15;
    cycle();
    jump = 0;
    cycle();
    lit_pc("pre_call", 13'd15);
    call = 1; target = 13'd32;
    cycle();
    call = 0;
    check("call_bubble", 32'(instr_valid), 32'd0);
    cycle();
    lit_pc("call_pc", 13'd32);
    run(5);
    lit_pc("call_37", 13'd37);
    ret = 1;
    cycle();
    ret = 0;
    check("ret_bubble", 32'(instr_valid), 32'd0);
    cycle();
    lit_pc("ret_pc", 13'd16);

    // interrupt at PC=9 (FA=10)
    jump = 1; target = 13'd9;
    cycle();
    jump = 0;
    cycle();
    lit_pc("pre_irq", 13'd9);
    irq = 1; en = 1;
    cycle();
    check("irq_ack", 32'(irq_ack), 32'd1);
    check("irq_bubble", 32'(instr_valid), 32'd0);
    check("irq_addr", 32'(prom_addr), 32'd4);
    cycle();
    check("irq_ack_pulse", 32'(irq_ack), 32'd0);
    lit_pc("isr_pc", 13'd4);
    cycle();
    check("irq_masked", 32'(irq_ack), 32'd0);
    irq = 0; reti = 1;
    cycle();
    reti = 0;
    check("reti_bubble", 32'(instr_valid), 32'd0);
    cycle();
    lit_pc("reti_pc", 13'd10);

    // stall with redirect and IRQ pending
    stall = 1; jump = 1; target = 13'd99; irq = 1; en = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      lit_pc("stall_pc", 13'd10);
      check("stall_addr", 32'(prom_addr), 32'd11);
      check("stall_ack", 32'(irq_ack), 32'd0);
    end
    stall = 0; jump = 0;
    cycle();
    check("post_stall_ack", 32'(irq_ack), 32'd1);
    irq = 0;
    cycle();
    lit_pc("isr2_pc", 13'd4);
    rst = 1;
    cycle();
    rst = 0;
    check("midisr_rst_valid", 32'(instr_valid), 32'd0);
    check("midisr_rst_addr", 32'(prom_addr), 32'd0);
    irq = 1;
    cycle();
    check("isr_cleared_ack", 32'(irq_ack), 32'd1);
    irq = 0; en = 0;
    run(2);

    // fetch address wrap
    jump = 1; target = 13'd8190;
    cycle();
    jump = 0;
    run(2);
    lit_pc("wrap_8191", 13'd8191);
    cycle();
    lit_pc("wrap_0", 13'd0);
    check("wrap_addr", 32'(prom_addr), 32'd1);

    // stack overflow / underflow
    rst = 1;
    cycle();
    rst = 0;
    cycle();
    for (int i = 0; i < 10; i++) begin
      call = 1; target = 13'(100 + 10 * i);
      cycle();
      call = 0;
      cycle();
      if (i == 7) check("err_after_8", 32'(stack_err), 32'd0);
      if (i == 8) check("err_after_9", 32'(stack_err), 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      ret = 1;
      cycle();
      ret = 0;
      cycle();
    end
    check("err_sticky", 32'(stack_err), 32'd1);
    ret = 1;
    cycle();
    ret = 0;
    check("uflow_bubble", 32'(instr_valid), 32'd0);
    cycle();
    lit_pc("uflow_pc", 13'd0);
    check("uflow_err", 32'(stack_err), 32'd1);
    run(3);
    check("err_still", 32'(stack_err), 32'd1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 199) == 0);
      stall  = ($urandom_range(0, 7) == 0);
      jump   = ($urandom_range(0, 9) == 0);
      call   = ($urandom_range(0, 7) == 0);
      ret    = ($urandom_range(0, 8) == 0);
      reti   = ($urandom_range(0, 14) == 0);
      irq    = ($urandom_range(0, 4) == 0);
      en     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) target = 13'(8191 - $urandom_range(0, 3));
      else target = 13'($urandom_range(0, 8191));
      cycle();
    end
    clear_inputs();
    rst = 0;
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prom_fetch_sequencer.md
Name: prom_fetch_sequencer

Overview:
- Instruction-fetch controller for the TRSQ8 core's combinational program ROM (13-bit address, 15-bit instruction word).
- Owns the program counter and sequences ROM addresses.
- Performs jump/call/return redirection through an 8-entry hardware return stack.
- Vectors a single external interrupt.
- Sits between the program ROM and the instruction decoder, which issues redirect commands for the instruction currently presented.

Parameters:
ADDR_W, 13, ROM address width
DATA_W, 15, instruction word width
STACK_DEPTH, 8, return-stack entries
RESET_VEC, 13'd0, fetch address after reset and on stack underflow
IRQ_VEC, 13'd4, interrupt service entry address

Ports:
CLK_ip  in  1  clock, all state updates on rising edge
RST_ip  in  1  reset, synchronous, active-high
PROM_ADDR_op  out  ADDR_W  fetch address to ROM (registered FA)
PROM_DATA_ip  in  DATA_W  ROM word at PROM_ADDR_op, same cycle
STALL_ip  in  1  hold all sequencer state
JUMP_ip  in  1  redirect to TARGET_ip
CALL_ip  in  1  push return address, redirect to TARGET_ip
RET_ip  in  1  pop, redirect to popped address
RETI_ip  in  1  as RET_ip, and also clears in-ISR flag
TARGET_ip  in  ADDR_W  jump/call target
IRQ_ip  in  1  level interrupt request
INT_EN_ip  in  1  global interrupt enable
INSTR_op  out  DATA_W  current instruction to decoder
INSTR_VALID_op  out  1  INSTR_op is to be executed
PC_op  out  ADDR_W  address of INSTR_op
IRQ_ACK_op  out  1  one-cycle pulse: interrupt taken
STACK_ERR_op  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (RST_ip=1 at edge):
  - FA=RESET_VEC; INSTR_op=0; PC_op=0; INSTR_VALID_op=0.
  - SP=0; in_isr=0; IRQ_ACK_op=0; STACK_ERR_op=0.
  - Reset overrides every other input, including mid-ISR and mid-stall.
- Stall: if STALL_ip=1 (and no reset):
  - All registers hold; IRQ_ACK_op=0.
  - Redirect and IRQ inputs are ignored (not queued).
- Normal advance (no stall, no redirect, no IRQ take):
  - INSTR_op<=PROM_DATA_ip; PC_op<=FA; INSTR_VALID_op<=1; FA<=FA+1.
  - FA wraps 8191 to 0 silently.
  - Result: one instruction per cycle, ROM latency 1 cycle.
- Redirects:
  - Honoured only when INSTR_VALID_op=1 and STALL_ip=0; ignored otherwise.
  - Priority RETI > RET > CALL > JUMP.
  - JUMP: FA<=TARGET_ip.
  - CALL: push PC_op+1 (mod 2^13); FA<=TARGET_ip.
  - RET: pop; FA<=popped value.
  - RETI: as RET, plus in_isr<=0.
  - In the redirect cycle the ROM word fetched at the old FA is squashed: INSTR_VALID_op<=0 next cycle; INSTR_op and PC_op still load normally. Redirect penalty is exactly one bubble.
- Stack:
  - SP range 0..STACK_DEPTH.
  - Push when SP=STACK_DEPTH: entry dropped, SP unchanged, STACK_ERR_op<=1; the redirect still occurs.
  - Pop when SP=0: FA<=RESET_VEC, STACK_ERR_op<=1.
  - STACK_ERR_op clears only on reset.
- Interrupt take:
  - Condition: IRQ_ip=1, INT_EN_ip=1, in_isr=0, STALL_ip=0, no honoured redirect this cycle.
  - Action: push FA (the word being fetched, which is squashed); FA<=IRQ_VEC; in_isr<=1; INSTR_VALID_op<=0 next cycle; IRQ_ACK_op<=1 for exactly one cycle.
  - The currently valid INSTR_op executes normally.
  - Push overflow follows the stack rules above.
  - A redirect in the same cycle wins; IRQ is re-evaluated on the next cycle.
  - No nesting: IRQ is masked while in_isr=1.
- PROM_ADDR_op equals FA at all times; it is not combinationally dependent on inputs.

Test Plan:
1. Release reset with ROM word[n]=n -> INSTR_VALID_op=1 from first post-reset edge; (PC_op,INSTR_op)=(0,0),(1,1),(2,2)... one per cycle.
2. JUMP_ip with TARGET_ip=20 while PC_op=5 -> next cycle INSTR_VALID_op=0; following cycle PC_op=20, valid=1.
3. CALL to 32 at PC_op=15 -> executes 32,33...; RET at PC_op=37 -> bubble, then PC_op=16.
4. Nine nested CALLs then one more -> STACK_ERR_op=1 after 9th push; RET with SP=0 -> PC_op=0 after bubble; STACK_ERR_op stays 1 until RST_ip.
5. IRQ_ip=1, INT_EN_ip=1 while PC_op=9 (FA=10) -> IRQ_ACK_op single pulse; PC_op=4 after bubble; second IRQ ignored; RETI -> PC_op=10.
6. STALL_ip=1 for 3 cycles with JUMP_ip and IRQ_ip asserted -> outputs frozen, no redirect, no ACK. Assert RST_ip mid-ISR -> next cycle valid=0, PROM_ADDR_op=0, in_isr cleared.
